cpureg_sequencer: RTL and testbench
===================================

Name: cpureg_sequencer

Overview:
Command-driven controller that sequences the register-file unit (RA/wr/rd) and the PC unit (M) over one shared 8-bit data bus. Accepts one command at a time over a valid/ready handshake (from keypad decode or a test host) and expands it into correctly timed wr/rd/M pulses. It sits between the key/command source and the reg_function/pc_function blocks and replaces direct switch control of RA, wr, rd and M.

Parameters:
WR_CYCLES, 1, cycles wr is held high per register write (1..15)
RD_CYCLES, 2, cycles rd is held high before read data is captured (1..15)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  3  opcode: 000 NOP, 001 WRREG, 010 RDREG, 011 LDPC, 100 INCPC, 101 MOVRP, 110 FILL, 111 reserved
cmd_ra  input  2  register address for the command
cmd_data  input  8  command data operand
rdata  input  8  read data returned by the register file
RA  output  2  register address to the register file
wr  output  1  register write strobe
rd  output  1  register read strobe
M  output  2  PC mode: 00 hold, 01 load from dout, 10 increment, 11 unused (never driven)
dout  output  8  data bus to the register file and PC
result  output  8  last captured read value
done  output  1  one-cycle pulse when a command completes
err  output  1  reserved opcode seen; sticky until next accept
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (clr=1, asynchronous): state IDLE; RA=0, wr=0, rd=0, M=00, dout=0, result=0, done=0, err=0, busy=0; cmd_ready=0 while clr is high, 1 in the first cycle after release.
- cmd_ready = (state==IDLE) and not clr. Accept = cmd_valid and cmd_ready at a rising edge; latch op/ra/data and clear err. No queueing; cmd_valid is ignored while not ready.
- States: IDLE, WRITE, READ, PCOP, DONE. The accept edge moves to the first op state; the op state runs in the following cycle.
- WRREG: WRITE for WR_CYCLES cycles (wr=1, RA=ra, dout=data) -> DONE.
- RDREG: READ for RD_CYCLES cycles (rd=1, RA=ra); result<=rdata at the edge ending the last READ cycle -> DONE.
- LDPC: PCOP for 1 cycle (M=01, dout=data) -> DONE. INCPC: PCOP for 1 cycle (M=10) -> DONE.
- MOVRP: READ as RDREG, with rdata also copied to the internal data register; then PCOP for 1 cycle (M=01, dout=captured) -> DONE.
- FILL: for i=0..3, WRITE for WR_CYCLES cycles each with RA=i and dout=(data+i) mod 256; wr stays high across register boundaries -> DONE.
- NOP: IDLE -> DONE directly. Reserved opcode 111: IDLE -> DONE, err<=1.
- DONE: done=1 for exactly 1 cycle, then IDLE. busy=1 in WRITE/READ/PCOP/DONE.
- Outside active states: wr=0, rd=0, M=00. RA and dout hold their last driven values. wr and rd are never high together. M is non-zero only in PCOP.
- All outputs are registered (no combinational path from cmd_* to wr/rd/M).
- clr mid-command aborts immediately. Strobes drop asynchronously, there is no DONE pulse, and result keeps 0.

Test Plan:
- Reset: assert clr for 3 cycles with cmd_valid=1 -> no strobes; cmd_ready=0 during clr, 1 the cycle after release.
- WRREG ra=2 data=0x5A -> wr=1, RA=2, dout=0x5A for 1 cycle starting the cycle after accept; done pulses the next cycle; cmd_ready returns 1.
- RDREG ra=1 with rdata=0xC3 -> rd high for exactly 2 cycles, RA=1; result=0xC3; done pulses once; wr stays 0.
- MOVRP ra=3 with rdata=0x7E -> 2 rd cycles, then 1 cycle M=01 with dout=0x7E, then done; result=0x7E.
- FILL data=0xFE -> 4 consecutive wr cycles with (RA,dout) = (0,FE),(1,FF),(2,00),(3,01); then done.
- Opcode 111 -> done after 1 cycle with err=1 and no strobes; next INCPC accept clears err and gives M=10 for 1 cycle. clr raised during FILL's 2nd write drops wr at once with no done pulse.

Source files
------------

// File: rtl/cpureg_sequencer.sv
// cpureg_sequencer: expands one accepted command into timed wr/rd/M strobes on a shared data bus
module cpureg_sequencer #(
  parameter int WR_CYCLES = 1,
  parameter int RD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_ra,
  input  logic [7:0] cmd_data,
  input  logic [7:0] rdata,
  output logic [1:0] RA,
  output logic       wr,
  output logic       rd,
  output logic [1:0] M,
  output logic [7:0] dout,
  output logic [7:0] result,
  output logic       done,
  output logic       err,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, PCOP, DONE} state_t;
  localparam logic [2:0] WRREG = 3'd1, RDREG = 3'd2, LDPC = 3'd3, INCPC = 3'd4, MOVRP = 3'd5, FILL = 3'd6;
  localparam logic [3:0] WR_LAST = 4'(WR_CYCLES - 1);
  localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);
  state_t state;
  logic [2:0] op;
  logic [7:0] data;
  logic [3:0] cnt;
  logic [1:0] idx;
  assign cmd_ready = state == IDLE && !clr;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      op <= '0;
      data <= '0;
      cnt <= '0;
      idx <= '0;
      RA <= '0;
      wr <= 1'b0;
      rd <= 1'b0;
      M <= 2'b00;
      dout <= '0;
      result <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else
      case (state)
        IDLE: if (cmd_valid) begin
          op <= cmd_op;
          data <= cmd_data;
          err <= cmd_op == 3'd7;
          cnt <= '0;
          idx <= '0;
          case (cmd_op)
            WRREG, FILL: begin
              state <= WRITE;
              wr <= 1'b1;
              RA <= cmd_op == FILL ? 2'd0 : cmd_ra;
              dout <= cmd_data;
            end
            RDREG, MOVRP: begin
              state <= READ;
              rd <= 1'b1;
              RA <= cmd_ra;
            end
            LDPC: begin
              state <= PCOP;
              M <= 2'b01;
              dout <= cmd_data;
            end
            INCPC: begin
              state <= PCOP;
              M <= 2'b10;
            end
            default: begin
              state <= DONE;
              done <= 1'b1;
            end
          endcase
        end
        WRITE: if (cnt != WR_LAST) cnt <= cnt + 4'd1;
        else if (op == FILL && idx != 2'd3) begin
          // wr stays high while stepping to the next register
          cnt <= '0;
          idx <= idx + 2'd1;
          RA <= idx + 2'd1;
          dout <= data + {6'd0, idx} + 8'd1;
        end else begin
          wr <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        READ: if (cnt != RD_LAST) cnt <= cnt + 4'd1;
        else begin
          rd <= 1'b0;
          result <= rdata;
          if (op == MOVRP) begin
            data <= rdata;
            dout <= rdata;
            M <= 2'b01;
            state <= PCOP;
          end else begin
            done <= 1'b1;
            state <= DONE;
          end
        end
        PCOP: begin
          M <= 2'b00;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_cpureg_sequencer.sv
// tb_cpureg_sequencer: directed self-checking bench for cpureg_sequencer
module tb_cpureg_sequencer;
  logic clk = 1'b0, clr = 1'b1, cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_ra = '0, RA, M;
  logic [7:0] cmd_data = '0, rdata = '0, dout, result;
  logic wr, rd, done, err, busy;
  int total = 0, bad = 0;

  cpureg_sequencer dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_data(cmd_data), .rdata(rdata),
    .RA(RA), .wr(wr), .rd(rd), .M(M), .dout(dout), .result(result),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic [1:0] ra, input logic [7:0] d);
    @(negedge clk);
    cmd_op = op;
    cmd_ra = ra;
    cmd_data = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 3'd1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({wr, rd, M, done, cmd_ready} !== 6'b0) begin bad++; $display("FAIL reset_strobes: got %b want 000000", {wr, rd, M, done, cmd_ready}); end
    end
    clr = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    total++;
    if ({busy, RA, dout, result, err, done} !== 21'b0) begin bad++; $display("FAIL reset_regs: got %h want 0", {busy, RA, dout, result, err, done}); end
  endtask

  task automatic test_wrreg;
    issue(3'd1, 2'd2, 8'h5A);
    total++;
    if ({wr, rd, RA, dout} !== {1'b1, 1'b0, 2'd2, 8'h5A}) begin bad++; $display("FAIL wrreg_strobe: got wr=%b rd=%b RA=%0d dout=%h want 1 0 2 5a", wr, rd, RA, dout); end
    total++;
    if ({done, cmd_ready, busy} !== 3'b001) begin bad++; $display("FAIL wrreg_busy: got %b want 001", {done, cmd_ready, busy}); end
    @(negedge clk);
    total++;
    if ({wr, done, busy} !== 3'b011) begin bad++; $display("FAIL wrreg_done: got %b want 011", {wr, done, busy}); end
    @(negedge clk);
    total++;
    if ({done, cmd_ready, busy} !== 3'b010) begin bad++; $display("FAIL wrreg_idle: got %b want 010", {done, cmd_ready, busy}); end
  endtask

  task automatic test_rdreg;
    int rd_n = 0, done_n = 0, wr_n = 0, ra_bad = 0;
    rdata = 8'hC3;
    issue(3'd2, 2'd1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      rd_n += int'(rd);
      done_n += int'(done);
      wr_n += int'(wr);
      ra_bad += int'(rd && RA != 2'd1);
      @(negedge clk);
    end
    total++;
    if (rd_n != 2) begin bad++; $display("FAIL rdreg_rd_cycles: got %0d want 2", rd_n); end
    total++;
    if (done_n != 1) begin bad++; $display("FAIL rdreg_done_pulses: got %0d want 1", done_n); end
    total++;
    if (wr_n + ra_bad != 0) begin bad++; $display("FAIL rdreg_wr_ra: got wr=%0d ra_bad=%0d want 0 0", wr_n, ra_bad); end
    total++;
    if (result !== 8'hC3) begin bad++; $display("FAIL rdreg_result: got %h want c3", result); end
  endtask

  task automatic test_movrp;
    rdata = 8'h7E;
    issue(3'd5, 2'd3, 8'h00);
    total++;
    if ({rd, RA, M} !== {1'b1, 2'd3, 2'b00}) begin bad++; $display("FAIL movrp_rd1: got rd=%b RA=%0d M=%b want 1 3 00", rd, RA, M); end
    @(negedge clk);
    total++;
    if ({rd, M} !== 3'b100) begin bad++; $display("FAIL movrp_rd2: got %b want 100", {rd, M}); end
    @(negedge clk);
    rdata = 8'h00;
    total++;
    if ({rd, M, dout, done} !== {1'b0, 2'b01, 8'h7E, 1'b0}) begin bad++; $display("FAIL movrp_pc: got rd=%b M=%b dout=%h done=%b want 0 01 7e 0", rd, M, dout, done); end
    @(negedge clk);
    total++;
    if ({M, done, result} !== {2'b00, 1'b1, 8'h7E}) begin bad++; $display("FAIL movrp_done: got M=%b done=%b result=%h want 00 1 7e", M, done, result); end
    @(negedge clk);
  endtask

  task automatic test_ldpc;
    issue(3'd3, 2'd0, 8'h3C);
    total++;
    if ({wr, rd, M, dout} !== {2'b00, 2'b01, 8'h3C}) begin bad++; $display("FAIL ldpc_pc: got wr=%b rd=%b M=%b dout=%h want 0 0 01 3c", wr, rd, M, dout); end
    @(negedge clk);
    total++;
    if ({M, done} !== 3'b001) begin bad++; $display("FAIL ldpc_done: got %b want 001", {M, done}); end
    @(negedge clk);
  endtask

  task automatic test_fill;
    logic [7:0] e;
    issue(3'd6, 2'd2, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      e = 8'hFE + 8'(i);
      total++;
      if ({wr, RA, dout, done} !== {1'b1, 2'(i), e, 1'b0}) begin bad++; $display("FAIL fill_step%0d: got wr=%b RA=%0d dout=%h want 1 %0d %h", i, wr, RA, dout, i, e); end
      @(negedge clk);
    end
    total++;
    if ({wr, done} !== 2'b01) begin bad++; $display("FAIL fill_done: got %b want 01", {wr, done}); end
    @(negedge clk);
  endtask

  task automatic test_reserved;
    issue(3'd7, 2'd0, 8'h00);
    total++;
    if ({done, err, wr, rd, M} !== 6'b110000) begin bad++; $display("FAIL rsv_done: got %b want 110000", {done, err, wr, rd, M}); end
    @(negedge clk);
    total++;
    if ({done, err, cmd_ready} !== 3'b011) begin bad++; $display("FAIL rsv_sticky: got %b want 011", {done, err, cmd_ready}); end
    issue(3'd4, 2'd0, 8'h00);
    total++;
    if ({err, M} !== 3'b010) begin bad++; $display("FAIL incpc_pc: got err=%b M=%b want 0 10", err, M); end
    @(negedge clk);
    total++;
    if ({M, done} !== 3'b001) begin bad++; $display("FAIL incpc_done: got %b want 001", {M, done}); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int done_n = 0, wr_n = 0;
    issue(3'd6, 2'd0, 8'h10);
    @(negedge clk);
    total++;
    if ({wr, RA, dout} !== {1'b1, 2'd1, 8'h11}) begin bad++; $display("FAIL abort_pre: got wr=%b RA=%0d dout=%h want 1 1 11", wr, RA, dout); end
    #1 clr = 1'b1;
    #1;
    total++;
    if ({wr, busy, cmd_ready, M} !== 5'b0) begin bad++; $display("FAIL abort_drop: got %b want 00000", {wr, busy, cmd_ready, M}); end
    repeat (3) begin
      @(negedge clk);
      done_n += int'(done);
      wr_n += int'(wr);
    end
    total++;
    if (done_n + wr_n != 0 || result !== 8'h00) begin bad++; $display("FAIL abort_quiet: got done=%0d wr=%0d result=%h want 0 0 00", done_n, wr_n, result); end
    clr = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
  endtask

  initial begin
    test_reset;
    test_wrreg;
    test_rdreg;
    test_movrp;
    test_ldpc;
    test_fill;
    test_reserved;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
